// File: rtl/param_cpu_core.sv
// param_cpu_core: multi-cycle 16-register CPU with a fetch/decode/execute FSM.
// Instructions come from a synchronous ROM and data from a synchronous RAM.
// The 16-bit instruction fields are op=[15:12], d=[11:8], a=[7:4], b=[3:0]
// and k=[7:0].
//
// Parameters:
//   DATA_W  - register/data width (>= 8)
//   PC_W    - program counter / instruction address width
//   DMEM_AW - data memory address width
//
// Ports:
//   clk        - system clock, all state changes on posedge
//   rst        - synchronous active-high reset
//   run        - advance enable, sampled only in FETCH
//   imem_addr  - instruction address (the pc)
//   imem_data  - instruction word, valid the cycle after imem_addr
//   dmem_addr  - data address for LOAD/STORE
//   dmem_wdata - store data
//   dmem_we    - one-cycle store strobe
//   dmem_re    - one-cycle load strobe, dmem_rdata valid next cycle
//   dmem_rdata - load data
//   out_reg    - current value of R1
//   retire     - one-cycle pulse per completed instruction
//   halted     - high once a HALT has retired
module param_cpu_core #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  output logic               dmem_re,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DATA_W-1:0]  out_reg,
  output logic               retire,
  output logic               halted
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_SET   = 4'h3;
  localparam logic [3:0] OP_LT    = 4'h4;
  localparam logic [3:0] OP_EQ    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_BNEQ  = 4'h7;
  localparam logic [3:0] OP_ADD   = 4'h8;
  localparam logic [3:0] OP_SUB   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_AND   = 4'hC;
  localparam logic [3:0] OP_OR    = 4'hD;
  localparam logic [3:0] OP_INV   = 4'hE;
  localparam logic [3:0] OP_XOR   = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc, pc_nxt, pc_inc, br_tgt;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   regs [16];
  logic [3:0]          f_op, f_d, f_a, f_b;
  logic [7:0]          f_k;
  logic [DATA_W-1:0]   ra, rb, rd;
  logic [DMEM_AW-1:0]  mem_addr;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  // ALU for the register-register opcodes. Shift amounts are the full
  // unsigned R[b]; a shift by DATA_W or more yields 0 by SV shift semantics.
  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      OP_LT:   return {{(DATA_W-1){1'b0}}, (a < b)};
      OP_EQ:   return {{(DATA_W-1){1'b0}}, (a == b)};
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return a << b;
      OP_SHR:  return a >> b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_INV:  return ~a;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign f_op = ir[15:12];
  assign f_d  = ir[11:8];
  assign f_a  = ir[7:4];
  assign f_b  = ir[3:0];
  assign f_k  = ir[7:0];

  // Operands are read combinationally, so every read sees the value from
  // before this instruction's own write.
  assign ra = regs[f_a];
  assign rb = regs[f_b];
  assign rd = regs[f_d];

  assign pc_inc   = pc + 1'b1;
  // Casts truncate or zero-extend as needed; the low bits of a sum depend only
  // on the low bits of its operands.
  assign br_tgt   = PC_W'(rb);
  assign mem_addr = DMEM_AW'(ra) + DMEM_AW'(f_b);

  assign imem_addr = pc;
  assign out_reg   = regs[1];
  assign halted    = (state == S_HALT);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    retire     = 1'b0;
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    case (state)
      // FETCH: pc is on imem_addr; the ROM word arrives next cycle.
      S_FETCH: if (run) state_nxt = S_DECODE;
      // DECODE: ROM output is latched into ir.
      S_DECODE: state_nxt = S_EXEC;
      // EXEC: most instructions complete here.
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_inc;
        retire    = 1'b1;
        case (f_op)
          OP_NOP: begin
            if (f_d == 4'hF) begin
              state_nxt = S_HALT;
              pc_nxt    = pc;
            end
          end
          OP_LOAD: begin
            dmem_re   = 1'b1;
            dmem_addr = mem_addr;
            retire    = 1'b0;
            pc_nxt    = pc;
            state_nxt = S_MEM;
          end
          OP_STORE: begin
            dmem_we    = 1'b1;
            dmem_addr  = mem_addr;
            dmem_wdata = rd;
          end
          OP_SET: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(f_k);
          end
          OP_BEQ:  if (rd == ra) pc_nxt = br_tgt;
          OP_BNEQ: if (rd != ra) pc_nxt = br_tgt;
          default: begin
            rf_we    = 1'b1;
            rf_wdata = alu(f_op, ra, rb);
          end
        endcase
      end
      // MEM: load data returns from the RAM.
      S_MEM: begin
        rf_we     = 1'b1;
        rf_wdata  = dmem_rdata;
        pc_nxt    = pc_inc;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    // Reset aborts whatever is in flight, including external strobes.
    if (rst) begin
      dmem_we = 1'b0;
      dmem_re = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_DECODE) ir <= imem_data;
      if (rf_we) regs[f_d] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
module tb_param_cpu_core;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we, dmem_re;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] out_reg;
  logic          retire, halted;

  param_cpu_core #(.DATA_W(DW), .PC_W(PW), .DMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
    .out_reg(out_reg), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0]   rom [256];
  logic [DW-1:0] ram [256];
  logic          tb_we = 1'b0;
  logic [7:0]    tb_addr = '0;
  logic [DW-1:0] tb_data = '0;

  always @(posedge clk) imem_data <= rom[imem_addr];

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (dmem_we) ram[dmem_addr] <= dmem_wdata;
    dmem_rdata <= ram[dmem_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  int         ncyc, nret, we_cnt, re_cnt;
  int         ret_t [16];
  logic [7:0] pc_after [16];
  logic [15:0] out_after [16];
  logic [7:0] we_addr, re_addr;
  logic [15:0] we_data;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_reset();
    rst = 1'b1;
    run = 1'b1;
    step();
    step();
  endtask

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0F00;
  endtask

  task automatic run_prog(input int budget, input string name);
    logic prev;
    ncyc = 0; nret = 0; we_cnt = 0; re_cnt = 0;
    we_addr = '0; re_addr = '0; we_data = '0;
    prev = 1'b0;
    while (!halted && ncyc < budget) begin
      step();
      ncyc++;
      if (prev && nret > 0) begin
        pc_after[nret-1]  = imem_addr;
        out_after[nret-1] = out_reg;
      end
      prev = retire;
      if (dmem_we) begin we_cnt++; we_addr = dmem_addr; we_data = dmem_wdata; end
      if (dmem_re) begin re_cnt++; re_addr = dmem_addr; end
      if (retire && nret < 16) begin ret_t[nret] = ncyc; nret++; end
    end
    check({name, " reached halt"}, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    int  bad;
    logic found;
    logic [7:0] pc_hold;

    vecs[0]  = '{4'h9, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[1]  = '{4'hA, 16'h0001, 16'h0010, 16'h0000};
    vecs[2]  = '{4'hA, 16'h0001, 16'h000F, 16'h8000};
    vecs[3]  = '{4'hB, 16'h8000, 16'h000F, 16'h0001};
    vecs[4]  = '{4'hB, 16'hFFFF, 16'h0011, 16'h0000};
    vecs[5]  = '{4'h4, 16'h8000, 16'h0001, 16'h0000};
    vecs[6]  = '{4'h4, 16'h0001, 16'h8000, 16'h0001};
    vecs[7]  = '{4'hE, 16'h0000, 16'h1234, 16'hFFFF};
    vecs[8]  = '{4'h8, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[9]  = '{4'h5, 16'h1234, 16'h1234, 16'h0001};
    vecs[10] = '{4'h5, 16'h1234, 16'h1235, 16'h0000};
    vecs[11] = '{4'hC, 16'hF0F0, 16'hFF00, 16'hF000};
    vecs[12] = '{4'hD, 16'hF0F0, 16'h0F00, 16'hFFF0};
    vecs[13] = '{4'hF, 16'hFFFF, 16'h00FF, 16'hFF00};

    // Reset state, then SET/SET/ADD
    rom_clear();
    rom[0] = 16'h3105; rom[1] = 16'h3203; rom[2] = 16'h8112;
    begin_reset();
    rst = 1'b0;
    check("rst imem_addr", imem_addr, 0);
    check("rst out_reg", out_reg, 0);
    check("rst retire", retire, 0);
    check("rst halted", halted, 0);
    check("rst dmem_we", dmem_we, 0);
    check("rst dmem_re", dmem_re, 0);
    check("rst dmem_addr", dmem_addr, 0);
    run_prog(40, "setadd");
    check("setadd first retire cycle", ret_t[0], 2);
    check("setadd retire gap 1", ret_t[1] - ret_t[0], 3);
    check("setadd retire gap 2", ret_t[2] - ret_t[1], 3);
    check("setadd pc after 0", pc_after[0], 1);
    check("setadd pc after 1", pc_after[1], 2);
    check("setadd pc after 2", pc_after[2], 3);
    check("setadd out after SET", out_after[0], 5);
    check("setadd out after ADD", out_after[2], 8);
    check("setadd retire count", nret, 4);

    // Store/load round trip
    rom_clear();
    rom[0] = 16'h32A5; rom[1] = 16'h3310; rom[2] = 16'h2232;
    rom[3] = 16'h1432; rom[4] = 16'h8140;
    begin_reset();
    poke(8'h12, 16'h0000);
    rst = 1'b0;
    run_prog(60, "ldst");
    check("ldst store count", we_cnt, 1);
    check("ldst store addr", we_addr, 8'h12);
    check("ldst store data", we_data, 16'h00A5);
    check("ldst load count", re_cnt, 1);
    check("ldst load addr", re_addr, 8'h12);
    check("ldst store latency", ret_t[2] - ret_t[1], 3);
    check("ldst load latency", ret_t[3] - ret_t[2], 4);
    check("ldst ram content", ram[8'h12], 16'h00A5);
    check("ldst R4 via R1", out_reg, 16'h00A5);

    // Branches: BEQ taken, BNEQ not taken
    rom_clear();
    rom[0] = 16'h3206; rom[1] = 16'h6002; rom[2] = 16'h31EE;
    rom[6] = 16'h7002; rom[7] = 16'h3177;
    begin_reset();
    rst = 1'b0;
    run_prog(60, "branch");
    check("branch BEQ target", pc_after[1], 6);
    check("branch BNEQ fallthrough", pc_after[2], 7);
    check("branch HALT pc", pc_after[4], 8);
    check("branch out_reg", out_reg, 16'h0077);

    // PC wrap 0xFF -> 0x00 and BEQ not taken
    rom_clear();
    rom[0] = 16'h32FF; rom[1] = 16'h6102; rom[8'hFF] = 16'h313C;
    begin_reset();
    rst = 1'b0;
    run_prog(60, "wrap");
    check("wrap jump to FF", pc_after[1], 8'hFF);
    check("wrap FF to 00", pc_after[2], 8'h00);
    check("wrap BEQ not taken", pc_after[4], 8'h02);
    check("wrap retire count", nret, 6);
    check("wrap out_reg", out_reg, 16'h003C);

    // ALU vector table, operands supplied from RAM
    for (int i = 0; i < 14; i++) begin
      rom_clear();
      rom[0] = 16'h1200; rom[1] = 16'h1301;
      rom[2] = {vecs[i].op, 12'h123};
      begin_reset();
      poke(8'h00, vecs[i].a);
      poke(8'h01, vecs[i].b);
      rst = 1'b0;
      run_prog(60, $sformatf("vec%0d", i));
      check($sformatf("vec%0d op%0h result", i, vecs[i].op), out_reg, vecs[i].exp);
    end

    // run low, then HALT, then reset out of HALT
    rom_clear();
    rom[0] = 16'h3305; rom[1] = 16'h8333; rom[2] = 16'h8130;
    begin_reset();
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (retire) found = 1'b1;
    end
    check("run first retire seen", found, 1);
    run = 1'b0;
    step();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (retire || imem_addr != 8'd1) bad++;
    end
    check("run low stall cycles bad", bad, 0);
    check("run low pc held", imem_addr, 1);
    run = 1'b1;
    run_prog(40, "halt");
    check("halt self-add result", out_reg, 16'd10);
    check("halt pc", imem_addr, 3);
    pc_hold = imem_addr;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (retire || imem_addr != pc_hold || !halted) bad++;
    end
    check("halt frozen cycles bad", bad, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("halt rst pc", imem_addr, 0);
    check("halt rst halted", halted, 0);
    check("halt rst out_reg", out_reg, 0);

    // Reset landing on the EXEC cycle of a STORE
    rom_clear();
    rom[0] = 16'h315A; rom[1] = 16'h2104;
    begin_reset();
    poke(8'h04, 16'h0011);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (dmem_we) found = 1'b1;
    end
    check("strst store reached", found, 1);
    check("strst store addr", dmem_addr, 8'h04);
    check("strst store data", dmem_wdata, 16'h005A);
    rst = 1'b1;
    #1;
    check("strst we forced low", dmem_we, 0);
    check("strst retire forced low", retire, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("strst ram unchanged", ram[8'h04], 16'h0011);
    check("strst pc", imem_addr, 0);
    check("strst out_reg", out_reg, 0);
    check("strst halted", halted, 0);
    check("strst dmem_we after", dmem_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
